alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares one combinational ALU datapath (ADD/SUB/logic/shift/compare, including the XOR unit) between two requesters, e.g. the execute stage and an address/branch-compare unit. The block arbitrates round-robin with valid/ready handshakes and registers the ALU result into a single output slot. The response carries the winner's ID tag and is held until the consumer accepts it. It sits between the decode/issue logic and the ALU function units.

Parameters:
WIDTH, 32, operand/result width in bits
OPW, 4, opcode width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  OPW  requester 0 opcode
req0_a  in  WIDTH  requester 0 operand A
req0_b  in  WIDTH  requester 0 operand B
req1_valid / req1_ready / req1_op / req1_a / req1_b  same as req0, requester 1
rsp_valid  out  1  result slot full
rsp_ready  in  1  consumer accepts result
rsp_id  out  1  requester index owning the result
rsp_result  out  WIDTH  ALU result
rsp_zero  out  1  rsp_result == 0

Behaviour:
- Reset: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, last_grant=1 (so req0 wins first tie). reqN_ready=0 while rst is high.
- can_accept = !rsp_valid | rsp_ready. State: EMPTY (rsp_valid=0) / FULL (rsp_valid=1).
- Grant (combinational): only one valid -> that one; both valid -> the one != last_grant; none -> no grant. reqN_ready = can_accept & grantN. At most one ready high per cycle.
- On handshake (reqN_valid & reqN_ready): ALU computes from reqN operands. Next cycle: rsp_valid=1, rsp_id=N, rsp_result, rsp_zero loaded; last_grant=N. Latency: 1 cycle, accept -> rsp_valid.
- FULL & rsp_ready & new grant: old result retires, new result loads the same edge. Throughput: 1 op/cycle.
- FULL & !rsp_ready: all readies 0; rsp_* held stable (no change while valid & !ready).
- FULL & rsp_ready & no grant: rsp_valid -> 0; rsp_result/rsp_id hold their last values.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU. Shifts use b[4:0]. ADD/SUB wrap modulo 2^WIDTH. SLT/SLTU give 0 or 1 zero-extended. Undefined opcodes give result 0, still handshake normally.
- Requester contract: valid and payload stable until ready. The arbiter does not require this, because grant is re-evaluated every cycle.
- Reset mid-operation: the pending result is discarded (rsp_valid=0). Any in-flight requester must re-present its request.

Optional Feature:
ALU_ARB_PERF_CNT_EN: when defined, adds outputs grant_cnt0, grant_cnt1 (32 bits each) and stall_cnt (32 bits). grant_cntN increments on each reqN handshake. stall_cnt increments each cycle rsp_valid & !rsp_ready. All reset to 0 and wrap at 2^32. When not defined, these ports and registers do not exist.

Decomposition:
- Package alu_pkg: opcode localparams (ALU_ADD..ALU_SLTU), OPW, default WIDTH.
- Sub-module alu_core: purely combinational (op, a, b -> result). It is reused by the execute stage.
- The arbiter holds only the grant logic, last_grant, and the output register.

Test Plan:
- After reset, req0 only: XOR a=0x0F0F00FF, b=0xF0FA00FF, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=0xFFF50000, rsp_zero=0.
- Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1. req0 ADD 5+7 -> 12. req1 SUB 3-3 -> 0 with rsp_zero=1.
- Backpressure: rsp_ready=0 for 3 cycles while both valid -> both readies 0, rsp_* frozen. rsp_ready=1 -> retire and load next result on the same edge.
- Boundaries: ADD 0xFFFFFFFF+1 -> 0. SRA 0x80000000 by 31 -> 0xFFFFFFFF. SLT 0xFFFFFFFF,1 -> 1. SLTU 0xFFFFFFFF,1 -> 0. Opcode 15 -> 0.
- rst asserted while rsp_valid=1 -> next cycle rsp_valid=0. First post-reset tie grants req0.
- With ALU_ARB_PERF_CNT_EN: 10 alternating grants plus 4 stall cycles -> grant_cnt0=5, grant_cnt1=5, stall_cnt=4.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Desc   : Opcode encodings and default widths for the shared ALU datapath.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OPW   = 4;

    localparam logic [ALU_OPW-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OPW-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OPW-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_OPW-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_OPW-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_OPW-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALU_OPW-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_OPW-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_OPW-1:0] ALU_SLT  = 4'd8;
    localparam logic [ALU_OPW-1:0] ALU_SLTU = 4'd9;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module : alu_core
// Desc   : Purely combinational ALU (add/sub/logic/shift/compare).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic [OPW-1:0]   i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result
);

    logic [4:0] w_shamt;
    logic       w_slt;
    logic       w_sltu;

    assign w_shamt = i_b[4:0];
    assign w_slt   = ($signed(i_a) < $signed(i_b));
    assign w_sltu  = (i_a < i_b);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SLL:  o_result = i_a << w_shamt;
            ALU_SRL:  o_result = i_a >> w_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
            ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_slt};
            ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, w_sltu};
            default:  o_result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module : alu_share_arbiter
// Desc   : Round-robin share of one ALU between two requesters with a single
//          registered result slot. Optional counters: ALU_ARB_PERF_CNT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
`ifdef ALU_ARB_PERF_CNT_EN
    ,
    output logic [31:0]      grant_cnt0,
    output logic [31:0]      grant_cnt1,
    output logic [31:0]      stall_cnt
`endif
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic             r_last_grant;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;

    logic             w_can_accept;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_fire0;
    logic             w_fire1;
    logic             w_fire;
    logic [OPW-1:0]   w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_result;

    // last_grant==1 means requester 0 wins the next tie
    assign w_can_accept = (r_state == ST_EMPTY) | rsp_ready;
    assign w_grant0     = req0_valid & (~req1_valid | r_last_grant);
    assign w_grant1     = req1_valid & (~req0_valid | ~r_last_grant);
    assign w_fire0      = ~rst & w_can_accept & w_grant0;
    assign w_fire1      = ~rst & w_can_accept & w_grant1;
    assign w_fire       = w_fire0 | w_fire1;

    assign req0_ready   = w_fire0;
    assign req1_ready   = w_fire1;

    assign w_op = w_grant1 ? req1_op : req0_op;
    assign w_a  = w_grant1 ? req1_a  : req0_a;
    assign w_b  = w_grant1 ? req1_b  : req0_b;

    alu_core #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu_core (
        .i_op     (w_op),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_result (w_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_EMPTY;
            r_last_grant <= 1'b1;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
        end else if (w_fire) begin
            r_state      <= ST_FULL;
            r_last_grant <= w_fire1;
            r_rsp_id     <= w_fire1;
            r_rsp_result <= w_result;
            r_rsp_zero   <= (w_result == '0);
        end else if (rsp_ready) begin
            r_state      <= ST_EMPTY;
        end
    end

    assign rsp_valid  = (r_state == ST_FULL);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;

`ifdef ALU_ARB_PERF_CNT_EN
    logic [31:0] r_grant_cnt0;
    logic [31:0] r_grant_cnt1;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_fire0)
                r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
            if (w_fire1)
                r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
            if (rsp_valid & ~rsp_ready)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
    assign stall_cnt  = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// Module : tb_alu_share_arbiter
// Desc   : Directed self-checking bench for alu_share_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [31:0] rsp_result;
`ifdef ALU_ARB_PERF_CNT_EN
    logic [31:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
`ifdef ALU_ARB_PERF_CNT_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd1;
        req1_op = 4'd0; req1_a = 32'd2; req1_b = 32'd2;
        tick();
        tick();
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp got v=%b id=%b r=%h z=%b exp 0 0 0 0", rsp_valid, rsp_id, rsp_result, rsp_zero);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_xor;
        req0_valid = 1'b1; req0_op = 4'd4;
        req0_a = 32'h0F0F00FF; req0_b = 32'hF0FA00FF; rsp_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL xor_ready got %b%b exp 10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'hFFF50000 || rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL xor_rsp got v=%b id=%b r=%h z=%b exp 1 0 fff50000 0", rsp_valid, rsp_id, rsp_result, rsp_zero);
        end
    endtask

    // last grant after test_xor was requester 0, so the first tie goes to 1
    task automatic test_alternate;
        logic exp_id;
        exp_id = 1'b1;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7;
        req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'd3; req1_b = 32'd3;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (req0_ready !== ~exp_id || req1_ready !== exp_id) begin
                errors++;
                $display("FAIL alt_ready[%0d] got %b%b exp %b%b", i, req0_ready, req1_ready, ~exp_id, exp_id);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id ||
                rsp_result !== (exp_id ? 32'd0 : 32'd12) || rsp_zero !== exp_id) begin
                errors++;
                $display("FAIL alt_rsp[%0d] got v=%b id=%b r=%0d z=%b exp id=%b", i, rsp_valid, rsp_id, rsp_result, rsp_zero, exp_id);
            end
            exp_id = ~exp_id;
        end
    endtask

    // slot holds id0/12 from the last alternate cycle
    task automatic test_backpressure;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready[%0d] got %b%b exp 00", i, req0_ready, req1_ready);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd12 || rsp_zero !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b id=%b r=%0d z=%b exp 1 0 12 0", i, rsp_valid, rsp_id, rsp_result, rsp_zero);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready got %b%b exp 01", req0_ready, req1_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin
            errors++;
            $display("FAIL bp_reload got v=%b id=%b r=%0d z=%b exp 1 1 0 1", rsp_valid, rsp_id, rsp_result, rsp_zero);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL drain got v=%b id=%b exp 0 1", rsp_valid, rsp_id);
        end
    endtask

    task automatic test_boundaries;
        logic [3:0]  ops [9];
        logic [31:0] as  [9];
        logic [31:0] bs  [9];
        logic [31:0] exp [9];
        ops = '{4'd0, 4'd7, 4'd8, 4'd9, 4'd15, 4'd5, 4'd6, 4'd2, 4'd3};
        as  = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678,
                32'h00000001, 32'h80000000, 32'hF0F0F0F0, 32'hF0F0F0F0};
        bs  = '{32'h1, 32'd31, 32'h1, 32'h1, 32'h9ABCDEF0,
                32'h24, 32'd31, 32'h0FF00FF0, 32'h0F000000};
        exp = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0,
                32'h10, 32'h1, 32'h00F000F0, 32'hFFF0F0F0};
        rsp_ready = 1'b1;
        req0_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            req0_op = ops[i]; req0_a = as[i]; req0_b = bs[i];
            #1;
            checks++;
            if (req0_ready !== 1'b1) begin
                errors++;
                $display("FAIL bnd_ready[%0d] got %b exp 1", i, req0_ready);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== exp[i] ||
                rsp_zero !== (exp[i] == 32'd0)) begin
                errors++;
                $display("FAIL bnd_rsp[%0d] op=%0d got v=%b r=%h z=%b exp r=%h", i, ops[i], rsp_valid, rsp_result, rsp_zero, exp[i]);
            end
        end
        req0_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        req1_valid = 1'b1; req1_op = 4'd3; req1_a = 32'h5; req1_b = 32'hA;
        rsp_ready = 1'b0;
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'hF) begin
            errors++;
            $display("FAIL mid_load got v=%b id=%b r=%h exp 1 1 f", rsp_valid, rsp_id, rsp_result);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_valid got %b exp 0", rsp_valid);
        end
        rst = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd2;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL first_tie got %b%b exp 10", req0_ready, req1_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd3) begin
            errors++;
            $display("FAIL first_tie_rsp got v=%b id=%b r=%0d exp 1 0 3", rsp_valid, rsp_id, rsp_result);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        tick();
    endtask

`ifdef ALU_ARB_PERF_CNT_EN
    task automatic test_perf;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rsp_ready = 1'b1;
        checks++;
        if (grant_cnt0 !== 32'd5 || grant_cnt1 !== 32'd5 || stall_cnt !== 32'd4) begin
            errors++;
            $display("FAIL perf got g0=%0d g1=%0d st=%0d exp 5 5 4", grant_cnt0, grant_cnt1, stall_cnt);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_xor();
        test_alternate();
        test_backpressure();
        test_boundaries();
        test_reset_mid();
`ifdef ALU_ARB_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
